// File: rtl/jk_excitation_driver.sv
// JK excitation driver: takes a target word, emits one JK code per cycle LSB first, then checks readback.
// Latency accept->done is WIDTH+2 cycles; tgt_ready only in IDLE, so tgt_valid is ignored while busy.
module jk_excitation_driver #(
  parameter int WIDTH      = 8,
  parameter bit USE_TOGGLE = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tgt_valid,
  input  logic [WIDTH-1:0]             tgt_data,
  output logic                         tgt_ready,
  input  logic [WIDTH-1:0]             q_fb,
  output logic [2*WIDTH-1:0]           jk,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [$clog2(WIDTH+1)-1:0]   chg_cnt
);

  localparam int CW = $clog2(WIDTH+1);
  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_FLUSH, S_CHECK} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_accept;
  logic                 w_diff;
  logic [1:0]           w_code;
  logic [2*WIDTH-1:0]   w_jk_nxt;
  logic [WIDTH-1:0]     r_tgt;
  logic [WIDTH-1:0]     r_snap;
  logic [IW-1:0]        r_idx;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_jk;
  logic                 r_done;
  logic                 r_err;
  logic [CW-1:0]        r_chg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (tgt_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: if (r_idx == IW'(WIDTH-1)) w_state_nxt = S_FLUSH;
      S_FLUSH: w_state_nxt = S_CHECK;
      S_CHECK: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Codes come from the snapshot, not live q_fb, so a toggle never compounds on an already-moved bit.
  always_comb begin
    w_diff   = r_tgt[r_idx] ^ r_snap[r_idx];
    w_code   = USE_TOGGLE ? 2'b11 : {r_tgt[r_idx], ~r_tgt[r_idx]};
    w_jk_nxt = '0;
    if (r_state == S_DRIVE && w_diff) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i == int'(r_idx)) w_jk_nxt[2*i +: 2] = w_code;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tgt  <= '0;
      r_snap <= '0;
      r_idx  <= '0;
      r_cnt  <= '0;
      r_jk   <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_chg  <= '0;
    end else begin
      r_jk   <= w_jk_nxt;
      r_done <= (r_state == S_CHECK);
      if (w_accept) begin
        r_tgt  <= tgt_data;
        r_snap <= q_fb;
        r_idx  <= '0;
        r_cnt  <= '0;
        r_err  <= 1'b0;
      end
      if (r_state == S_DRIVE) begin
        r_idx <= r_idx + IW'(1);
        if (w_diff) r_cnt <= r_cnt + CW'(1);
      end
      if (r_state == S_CHECK) begin
        r_err <= (q_fb != r_tgt);
        r_chg <= r_cnt;
      end
    end
  end

  assign tgt_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign jk        = r_jk;
  assign done      = r_done;
  assign err       = r_err;
  assign chg_cnt   = r_chg;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench: two 4-bit drivers (toggle and set/reset variants), each feeding a modelled JK bank.
module tb_jk_excitation_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vld_t = 1'b0, vld_s = 1'b0;
  logic [3:0] tgt_data = '0;
  logic       rdy_t, rdy_s, busy_t, busy_s, done_t, done_s, err_t, err_s;
  logic [7:0] jk_t, jk_s;
  logic [2:0] cnt_t, cnt_s;
  logic [3:0] bank_t, bank_s, q_t, q_s;
  logic [3:0] stuck_t = '0;
  logic       ld_t = 1'b0, ld_s = 1'b0;
  logic [3:0] ld_val = '0;
  int         n_run = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  jk_excitation_driver #(.WIDTH(4), .USE_TOGGLE(1'b1)) u_dut_t (
    .clk(clk), .rst_n(rst_n), .tgt_valid(vld_t), .tgt_data(tgt_data), .tgt_ready(rdy_t),
    .q_fb(q_t), .jk(jk_t), .busy(busy_t), .done(done_t), .err(err_t), .chg_cnt(cnt_t));

  jk_excitation_driver #(.WIDTH(4), .USE_TOGGLE(1'b0)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .tgt_valid(vld_s), .tgt_data(tgt_data), .tgt_ready(rdy_s),
    .q_fb(q_s), .jk(jk_s), .busy(busy_s), .done(done_s), .err(err_s), .chg_cnt(cnt_s));

  // JK bank model: 00 hold, 01 reset, 10 set, 11 toggle; not touched by rst_n
  function automatic logic [3:0] jk_apply(input logic [3:0] b, input logic [7:0] c);
    logic [3:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      case (c[2*i +: 2])
        2'b01:   r[i] = 1'b0;
        2'b10:   r[i] = 1'b1;
        2'b11:   r[i] = ~b[i];
        default: r[i] = b[i];
      endcase
    end
    return r;
  endfunction

  always @(posedge clk) begin
    bank_t <= ld_t ? ld_val : jk_apply(bank_t, jk_t);
    bank_s <= ld_s ? ld_val : jk_apply(bank_s, jk_s);
  end

  assign q_t = bank_t & ~stuck_t;
  assign q_s = bank_s;

  function automatic logic [7:0] o_jk(input bit s);   return s ? jk_s : jk_t;     endfunction
  function automatic logic       o_busy(input bit s); return s ? busy_s : busy_t; endfunction
  function automatic logic       o_done(input bit s); return s ? done_s : done_t; endfunction
  function automatic logic       o_err(input bit s);  return s ? err_s : err_t;   endfunction
  function automatic logic       o_rdy(input bit s);  return s ? rdy_s : rdy_t;   endfunction
  function automatic logic [2:0] o_cnt(input bit s);  return s ? cnt_s : cnt_t;   endfunction
  function automatic logic [3:0] o_q(input bit s);    return s ? q_s : q_t;       endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Preset the bank, run one full op, and check every cycle from accept to one past done.
  task automatic run_op(input bit s, input logic [3:0] q0, input logic [3:0] tg,
                        input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                        input logic [7:0] e3, input logic [3:0] eq, input logic ee,
                        input logic [2:0] ec);
    logic [7:0] ej [4];
    ej = '{e0, e1, e2, e3};
    ld_val = q0;
    if (s) ld_s = 1'b1; else ld_t = 1'b1;
    tick();
    ld_t = 1'b0;
    ld_s = 1'b0;
    chk($sformatf("op%0h_rdy", tg), o_rdy(s), 1);
    tgt_data = tg;
    if (s) vld_s = 1'b1; else vld_t = 1'b1;
    tick();
    vld_t = 1'b0;
    vld_s = 1'b0;
    tgt_data = ~tg;
    chk($sformatf("op%0h_acc_busy", tg), o_busy(s), 1);
    chk($sformatf("op%0h_acc_err", tg), o_err(s), 0);
    chk($sformatf("op%0h_acc_jk", tg), o_jk(s), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("op%0h_drive%0d_jk", tg, i), o_jk(s), ej[i]);
    end
    tick();
    chk($sformatf("op%0h_flush_jk", tg), o_jk(s), 0);
    chk($sformatf("op%0h_flush_done", tg), o_done(s), 0);
    tick();
    chk($sformatf("op%0h_done", tg), o_done(s), 1);
    chk($sformatf("op%0h_err", tg), o_err(s), ee);
    chk($sformatf("op%0h_cnt", tg), o_cnt(s), ec);
    chk($sformatf("op%0h_q", tg), o_q(s), eq);
    chk($sformatf("op%0h_done_rdy", tg), o_rdy(s), 1);
    tick();
    chk($sformatf("op%0h_done_pulse", tg), o_done(s), 0);
    chk($sformatf("op%0h_err_hold", tg), o_err(s), ee);
  endtask

  initial begin
    #12;
    chk("rst_jk", jk_t, 0);
    chk("rst_busy", busy_t, 0);
    chk("rst_done", done_t, 0);
    chk("rst_err", err_t, 0);
    chk("rst_cnt", cnt_s, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rel_rdy", rdy_t, 1);

    run_op(1'b0, 4'b0000, 4'b1010, 8'h00, 8'h0C, 8'h00, 8'hC0, 4'b1010, 1'b0, 3'd2);
    run_op(1'b1, 4'b1100, 4'b0101, 8'h02, 8'h00, 8'h00, 8'h40, 4'b0101, 1'b0, 3'd2);
    run_op(1'b1, 4'b1100, 4'b0001, 8'h02, 8'h00, 8'h10, 8'h40, 4'b0001, 1'b0, 3'd3);
    run_op(1'b0, 4'b0110, 4'b0110, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0110, 1'b0, 3'd0);

    stuck_t = 4'b0010;
    run_op(1'b0, 4'b0000, 4'b0010, 8'h00, 8'h0C, 8'h00, 8'h00, 4'b0000, 1'b1, 3'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stuck_err_hold%0d", i), err_t, 1);
    end
    stuck_t = 4'b0000;

    rst_n = 1'b0;
    #1;
    chk("idle_rst_err", err_t, 0);
    chk("idle_rst_busy", busy_t, 0);
    @(negedge clk);
    rst_n = 1'b1;

    ld_val = 4'b0000;
    ld_t = 1'b1;
    tick();
    ld_t = 1'b0;
    tgt_data = 4'b1111;
    vld_t = 1'b1;
    tick();
    vld_t = 1'b0;
    tick();
    chk("mid_jk_pre", jk_t, 8'h03);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_jk", jk_t, 0);
    chk("mid_rst_busy", busy_t, 0);
    chk("mid_rst_done", done_t, 0);
    chk("mid_rst_err", err_t, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("mid_rel_rdy", rdy_t, 1);

    ld_val = 4'b0000;
    ld_t = 1'b1;
    tick();
    ld_t = 1'b0;
    tgt_data = 4'b0011;
    vld_t = 1'b1;
    tick();
    tgt_data = 4'b1100;
    chk("b2b_acc1_busy", busy_t, 1);
    for (int k = 1; k <= 5; k++) tick();
    chk("b2b_pre_done1", done_t, 0);
    tick();
    chk("b2b_done1", done_t, 1);
    chk("b2b_rdy1", rdy_t, 1);
    chk("b2b_err1", err_t, 0);
    chk("b2b_cnt1", cnt_t, 2);
    chk("b2b_q1", q_t, 4'b0011);
    tick();
    vld_t = 1'b0;
    chk("b2b_acc2_busy", busy_t, 1);
    chk("b2b_acc2_done", done_t, 0);
    tick();
    chk("b2b_drive0_jk", jk_t, 8'h03);
    for (int k = 9; k <= 12; k++) tick();
    chk("b2b_pre_done2", done_t, 0);
    tick();
    chk("b2b_done2", done_t, 1);
    chk("b2b_err2", err_t, 0);
    chk("b2b_cnt2", cnt_t, 4);
    chk("b2b_q2", q_t, 4'b1100);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
